// File: rtl/monster_pkg.sv
// Shared types and default constants for the monster sprite controller.
// Also holds the bounded horizontal step used by the walk datapath.
package monster_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WALK   = 2'd1,
        SQUASH = 2'd2,
        DEAD   = 2'd3
    } monster_state_e;

    typedef enum logic [1:0] {
        TURN_NONE  = 2'b00,
        TURN_RIGHT = 2'b01,
        TURN_LEFT  = 2'b10
    } turn_e;

    localparam logic [9:0]  DEF_X_MIN          = 10'd32;
    localparam logic [9:0]  DEF_X_MAX          = 10'd600;
    localparam logic [9:0]  DEF_SPAWN_X        = 10'd320;
    localparam logic [9:0]  DEF_SPAWN_Y        = 10'd400;
    localparam logic [9:0]  DEF_STEP           = 10'd2;
    localparam int unsigned DEF_MOVE_DIV       = 2;
    localparam int unsigned DEF_DEATH_FRAMES   = 30;
    localparam int unsigned DEF_RESPAWN_FRAMES = 120;

    // 11-bit arithmetic so neither direction can wrap before clamping.
    function automatic logic [9:0] step_x(
        input logic [9:0] x,
        input logic       left,
        input logic [9:0] step,
        input logic [9:0] x_min,
        input logic [9:0] x_max
    );
        logic [10:0] sum;
        logic [9:0]  res;
        if (!left) begin
            sum = {1'b0, x} + {1'b0, step};
            res = (sum > {1'b0, x_max}) ? x_max : sum[9:0];
        end else begin
            sum = {1'b0, x_min} + {1'b0, step};
            res = ({1'b0, x} < sum) ? x_min : x - step;
        end
        return res;
    endfunction

endpackage

// File: rtl/monster_motion_if.sv
// Control/status bundle between the game logic and the monster controller.
interface monster_motion_if;
    logic       start;
    logic       kill;
    logic       dir;
    logic [1:0] turn;
    logic [9:0] MonsterX;
    logic [9:0] MonsterY;
    logic       alive;
    logic       squash;
    logic       anim_frame;

    modport master (
        output start, kill, dir,
        input  turn, MonsterX, MonsterY, alive, squash, anim_frame
    );

    modport slave (
        input  start, kill, dir,
        output turn, MonsterX, MonsterY, alive, squash, anim_frame
    );
endinterface

// File: rtl/monster_motion_frame_tick_div.sv
// Modulo-DIV frame counter; tick is high on the frame where the count wraps.
module frame_tick_div #(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam logic [3:0] LAST = 4'(DIV - 1);

    logic [3:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        cnt <= '0;
        else if (clear) cnt <= '0;
        else if (en)    cnt <= tick ? '0 : cnt + 4'd1;
    end
endmodule

// File: rtl/monster_motion.sv
// Patrolling monster: spawn, walk between bounds, squash on stomp, respawn.
// All outputs are registered from the next-state/datapath values.
module monster_motion
    import monster_pkg::*;
#(
    parameter logic [9:0]  X_MIN          = DEF_X_MIN,
    parameter logic [9:0]  X_MAX          = DEF_X_MAX,
    parameter logic [9:0]  SPAWN_X        = DEF_SPAWN_X,
    parameter logic [9:0]  SPAWN_Y        = DEF_SPAWN_Y,
    parameter logic [9:0]  STEP           = DEF_STEP,
    parameter int unsigned MOVE_DIV       = DEF_MOVE_DIV,
    parameter int unsigned DEATH_FRAMES   = DEF_DEATH_FRAMES,
    parameter int unsigned RESPAWN_FRAMES = DEF_RESPAWN_FRAMES
) (
    input  logic             frame_clk,
    input  logic             Reset,
    monster_motion_if.slave  bus
);
    localparam logic [15:0] DEATH_LAST   = 16'(DEATH_FRAMES - 1);
    localparam logic [15:0] RESPAWN_LAST = 16'(RESPAWN_FRAMES - 1);

    monster_state_e state, state_next;
    turn_e          turn, turn_next;
    logic [9:0]     x, x_next, y, y_next;
    logic           alive, squash, anim, anim_next;
    logic [2:0]     anim_cnt, anim_cnt_next;
    logic [15:0]    timer, timer_next;
    logic           move_tick;

    frame_tick_div #(.DIV(MOVE_DIV)) u_move_div (
        .clk   (frame_clk),
        .rst   (Reset),
        .clear (state != WALK),
        .en    (state == WALK),
        .tick  (move_tick)
    );

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            x        <= SPAWN_X;
            y        <= SPAWN_Y;
            turn     <= TURN_NONE;
            alive    <= 1'b0;
            squash   <= 1'b0;
            anim     <= 1'b0;
            anim_cnt <= '0;
            timer    <= '0;
        end else begin
            state    <= state_next;
            x        <= x_next;
            y        <= y_next;
            turn     <= turn_next;
            alive    <= (state_next == WALK);
            squash   <= (state_next == SQUASH);
            anim     <= anim_next;
            anim_cnt <= anim_cnt_next;
            timer    <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)            state_next = WALK;
            WALK:    if (bus.kill)             state_next = SQUASH;
            SQUASH:  if (timer == DEATH_LAST)   state_next = DEAD;
            DEAD:    if (timer == RESPAWN_LAST) state_next = WALK;
            default:                           state_next = IDLE;
        endcase
    end

    always_comb begin
        x_next        = x;
        y_next        = y;
        turn_next     = TURN_NONE;
        anim_next     = anim;
        anim_cnt_next = '0;
        timer_next    = '0;
        case (state)
            WALK: begin
                anim_cnt_next = anim_cnt + 3'd1;
                if (anim_cnt == 3'd7) anim_next = ~anim;
                // A stomp freezes position and suppresses the edge report.
                if (!bus.kill) begin
                    if (move_tick) x_next = step_x(x, bus.dir, STEP, X_MIN, X_MAX);
                    if (!bus.dir && x_next == X_MAX)     turn_next = TURN_RIGHT;
                    else if (bus.dir && x_next == X_MIN) turn_next = TURN_LEFT;
                end
            end
            SQUASH, DEAD: begin
                if (state_next == state) timer_next = timer + 16'd1;
            end
            default: ;
        endcase
        if (state != WALK && state_next == WALK) begin
            x_next    = SPAWN_X;
            y_next    = SPAWN_Y;
            anim_next = 1'b0;
        end
    end

    assign bus.turn       = turn;
    assign bus.MonsterX   = x;
    assign bus.MonsterY   = y;
    assign bus.alive      = alive;
    assign bus.squash     = squash;
    assign bus.anim_frame = anim;
endmodule

// File: tb/tb_monster_motion.sv
// Self-checking bench for monster_motion against a frame-level behavioural model.
module tb_monster_motion;
    localparam int XMIN  = 32;
    localparam int XMAX  = 600;
    localparam int SPX   = 320;
    localparam int SPY   = 400;
    localparam int STEP  = 2;
    localparam int MDIV  = 2;
    localparam int DEATH = 30;
    localparam int RESP  = 120;

    logic frame_clk = 1'b0;
    logic Reset     = 1'b0;

    monster_motion_if bus();

    monster_motion #(
        .X_MIN          (10'(XMIN)),
        .X_MAX          (10'(XMAX)),
        .SPAWN_X        (10'(SPX)),
        .SPAWN_Y        (10'(SPY)),
        .STEP           (10'(STEP)),
        .MOVE_DIV       (MDIV),
        .DEATH_FRAMES   (DEATH),
        .RESPAWN_FRAMES (RESP)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    int errors = 0;
    int checks = 0;

    // Model: mode 0 idle, 1 walking, 2 squashed, 3 dead.
    int m_mode, m_x, m_y, m_turn, m_anim, m_walk_edges, m_frames;

    task automatic model_reset();
        m_mode = 0; m_x = SPX; m_y = SPY; m_turn = 0;
        m_anim = 0; m_walk_edges = 0; m_frames = 0;
    endtask

    task automatic model_edge(input bit s, input bit k, input bit d);
        m_turn = 0;
        case (m_mode)
            0: if (s) begin
                m_mode = 1; m_x = SPX; m_y = SPY; m_walk_edges = 0; m_anim = 0;
            end
            1: begin
                if (!k && (m_walk_edges % MDIV) == MDIV - 1) begin
                    if (d) m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
                    else   m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
                end
                m_walk_edges++;
                m_anim = (m_walk_edges / 8) % 2;
                if (k) begin
                    m_mode = 2; m_frames = 0;
                end else if (!d && m_x == XMAX) m_turn = 1;
                else if (d && m_x == XMIN)     m_turn = 2;
            end
            2: begin
                m_frames++;
                if (m_frames == DEATH) begin m_mode = 3; m_frames = 0; end
            end
            default: begin
                m_frames++;
                if (m_frames == RESP) begin
                    m_mode = 1; m_x = SPX; m_y = SPY; m_walk_edges = 0; m_anim = 0;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit s, input bit k, input bit d);
        bus.start = s; bus.kill = k; bus.dir = d;
        @(posedge frame_clk);
        model_edge(s, k, d);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.kill = 1'b0; bus.dir = 1'b0;
        do_reset();
        checks++; if (int'(bus.MonsterX) !== SPX) begin errors++; $display("FAIL reset_x: got %0d expected %0d", bus.MonsterX, SPX); end
        checks++; if (int'(bus.MonsterY) !== SPY) begin errors++; $display("FAIL reset_y: got %0d expected %0d", bus.MonsterY, SPY); end
        checks++; if (bus.turn !== 2'b00) begin errors++; $display("FAIL reset_turn: got %b expected 00", bus.turn); end
        checks++; if (bus.alive !== 1'b0) begin errors++; $display("FAIL reset_alive: got %b expected 0", bus.alive); end
        checks++; if (bus.squash !== 1'b0) begin errors++; $display("FAIL reset_squash: got %b expected 0", bus.squash); end
        checks++; if (bus.anim_frame !== 1'b0) begin errors++; $display("FAIL reset_anim: got %b expected 0", bus.anim_frame); end
    endtask

    task automatic test_walk();
        int exp_x[5] = '{320, 320, 322, 322, 324};
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0);
            checks++;
            if (int'(bus.MonsterX) !== exp_x[i] || bus.alive !== 1'b1) begin
                errors++;
                $display("FAIL walk_x[%0d]: got x=%0d alive=%b expected x=%0d alive=1", i, bus.MonsterX, bus.alive, exp_x[i]);
            end
        end
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        checks++; if (bus.anim_frame !== 1'b0) begin errors++; $display("FAIL walk_anim_pre: got %b expected 0", bus.anim_frame); end
        cycle(1, 0, 0);
        checks++; if (bus.anim_frame !== 1'b1) begin errors++; $display("FAIL walk_anim_toggle: got %b expected 1", bus.anim_frame); end
    endtask

    task automatic test_right_edge();
        for (int i = 0; i < 1000 && m_x != 598; i++) cycle(1, 0, 0);
        checks++; if (int'(bus.MonsterX) !== 598) begin errors++; $display("FAIL right_approach: got %0d expected 598", bus.MonsterX); end
        for (int i = 0; i < 4 && m_x == 598; i++) cycle(1, 0, 0);
        checks++;
        if (int'(bus.MonsterX) !== 600 || bus.turn !== 2'b01) begin
            errors++; $display("FAIL right_hit: got x=%0d turn=%b expected x=600 turn=01", bus.MonsterX, bus.turn);
        end
        cycle(1, 0, 0);
        checks++;
        if (int'(bus.MonsterX) !== 600 || bus.turn !== 2'b01) begin
            errors++; $display("FAIL right_stale_dir: got x=%0d turn=%b expected x=600 turn=01", bus.MonsterX, bus.turn);
        end
        cycle(1, 0, 1);
        checks++;
        if (int'(bus.MonsterX) !== 598 || bus.turn !== 2'b00) begin
            errors++; $display("FAIL right_reverse: got x=%0d turn=%b expected x=598 turn=00", bus.MonsterX, bus.turn);
        end
    endtask

    task automatic test_left_edge();
        int min_x = 1023;
        for (int i = 0; i < 1000 && m_x != 34; i++) begin
            cycle(1, 0, 1);
            if (int'(bus.MonsterX) < min_x) min_x = int'(bus.MonsterX);
        end
        checks++; if (int'(bus.MonsterX) !== 34) begin errors++; $display("FAIL left_approach: got %0d expected 34", bus.MonsterX); end
        for (int i = 0; i < 4 && m_x == 34; i++) cycle(1, 0, 1);
        checks++;
        if (int'(bus.MonsterX) !== 32 || bus.turn !== 2'b10) begin
            errors++; $display("FAIL left_hit: got x=%0d turn=%b expected x=32 turn=10", bus.MonsterX, bus.turn);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1, 0, 1);
            if (int'(bus.MonsterX) < min_x) min_x = int'(bus.MonsterX);
            checks++;
            if (int'(bus.MonsterX) !== 32 || bus.turn !== 2'b10) begin
                errors++; $display("FAIL left_hold[%0d]: got x=%0d turn=%b expected x=32 turn=10", i, bus.MonsterX, bus.turn);
            end
        end
        checks++; if (min_x < XMIN) begin errors++; $display("FAIL left_floor: got min %0d expected >= %0d", min_x, XMIN); end
    endtask

    task automatic test_kill_edge();
        do_reset();
        for (int i = 0; i < 1000 && m_x != 598; i++) cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 0);
        checks++;
        if (bus.turn !== 2'b00 || bus.squash !== 1'b1 || bus.alive !== 1'b0 || int'(bus.MonsterX) !== 598) begin
            errors++; $display("FAIL kill_edge: got turn=%b squash=%b alive=%b x=%0d expected 00 1 0 598", bus.turn, bus.squash, bus.alive, bus.MonsterX);
        end
        for (int i = 0; i < DEATH - 1; i++) begin
            cycle(1, 1'($urandom % 2), 1'($urandom % 2));
            checks++;
            if (bus.squash !== 1'b1 || int'(bus.MonsterX) !== 598) begin
                errors++; $display("FAIL squash_hold[%0d]: got squash=%b x=%0d expected 1 598", i, bus.squash, bus.MonsterX);
            end
        end
        cycle(0, 0, 0);
        checks++;
        if (bus.squash !== 1'b0 || bus.alive !== 1'b0) begin
            errors++; $display("FAIL dead_entry: got squash=%b alive=%b expected 0 0", bus.squash, bus.alive);
        end
        for (int i = 0; i < RESP - 1; i++) begin
            cycle(0, 1'($urandom % 2), 0);
            checks++;
            if (bus.alive !== 1'b0 || bus.squash !== 1'b0) begin
                errors++; $display("FAIL dead_hold[%0d]: got alive=%b squash=%b expected 0 0", i, bus.alive, bus.squash);
            end
        end
        cycle(0, 0, 0);
        checks++;
        if (bus.alive !== 1'b1 || int'(bus.MonsterX) !== SPX || int'(bus.MonsterY) !== SPY) begin
            errors++; $display("FAIL respawn: got alive=%b x=%0d y=%0d expected 1 %0d %0d", bus.alive, bus.MonsterX, bus.MonsterY, SPX, SPY);
        end
    endtask

    task automatic test_reset_mid_squash();
        logic [24:0] got;
        do_reset();
        for (int i = 0; i < 11; i++) cycle(1, 0, 0);
        cycle(1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        #2 Reset = 1'b1;
        #1;
        got = {bus.MonsterX, bus.MonsterY, bus.turn, bus.alive, bus.squash, bus.anim_frame};
        checks++;
        if (got !== {10'(SPX), 10'(SPY), 2'b00, 3'b000}) begin
            errors++; $display("FAIL reset_mid_squash: got %h expected %h", got, {10'(SPX), 10'(SPY), 2'b00, 3'b000});
        end
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 60; i++) begin
            cycle(0, 1'($urandom % 2), 1'($urandom % 2));
            checks++;
            if (bus.alive !== 1'b0 || bus.squash !== 1'b0 || int'(bus.MonsterX) !== SPX) begin
                errors++; $display("FAIL idle_hold[%0d]: got alive=%b squash=%b x=%0d expected 0 0 %0d", i, bus.alive, bus.squash, bus.MonsterX, SPX);
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] got, exp;
        bit s, k, d;
        d = 1'b0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom % 8) != 0;
            k = ($urandom % 40) == 0;
            if (m_turn == 1)               d = 1'b1;
            else if (m_turn == 2)          d = 1'b0;
            else if ($urandom % 64 == 0)   d = ~d;
            if ($urandom % 700 == 0) do_reset();
            cycle(s, k, d);
            got = {bus.MonsterX, bus.MonsterY, bus.turn, bus.alive, bus.squash, bus.anim_frame};
            exp = {10'(m_x), 10'(m_y), 2'(m_turn), m_mode == 1, m_mode == 2, 1'(m_anim)};
            checks++;
            if (got !== exp) begin
                errors++; $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_walk();
        test_right_edge();
        test_left_edge();
        test_kill_edge();
        test_reset_mid_squash();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/monster_motion.md
MONSTER_MOTION -- requirements
Module: monster_motion

Interface
REQ-001 Parameter X_MIN, default 10'd32, left patrol bound in pixels.
REQ-002 Parameter X_MAX, default 10'd600, right patrol bound in pixels.
REQ-003 Parameter SPAWN_X / SPAWN_Y, default 10'd320 / 10'd400, spawn position.
REQ-004 Parameter STEP, default 10'd2, pixels moved per move tick.
REQ-005 Parameter MOVE_DIV, default 2, frames per move tick (1..15).
REQ-006 Parameter DEATH_FRAMES, default 30; RESPAWN_FRAMES, default 120.
REQ-007 frame_clk  in  1  frame-rate clock (one rising edge per video frame).
REQ-008 Reset  in  1  asynchronous, active-high reset.
REQ-009 start  in  1  level; enables the first spawn.
REQ-010 kill  in  1  stomp hit from player collision logic, sampled each frame.
REQ-011 dir  in  1  current walking direction from the direction FSM; 0 = right, 1 = left.
REQ-012 turn  out  2  edge report to the direction FSM: 00 none, 01 right edge reached, 10 left edge reached; 11 never driven.
REQ-013 MonsterX, MonsterY  out  10 each  top-left pixel position.
REQ-014 alive  out  1  high only in WALK.
REQ-015 squash  out  1  high only in SQUASH (sprite select).
REQ-016 anim_frame  out  1  walk-cycle sprite toggle.

Function
REQ-017 All state changes occur on the rising edge of frame_clk; all outputs registered.
REQ-018 FSM states: IDLE, WALK, SQUASH, DEAD.
REQ-019 IDLE -> WALK when start = 1; X/Y loaded with SPAWN_X/SPAWN_Y on that edge.
REQ-020 WALK -> SQUASH when kill = 1; X/Y frozen; kill ignored in all other states.
REQ-021 SQUASH -> DEAD after exactly DEATH_FRAMES frames in SQUASH.
REQ-022 DEAD -> WALK after exactly RESPAWN_FRAMES frames in DEAD, reloading the spawn position; start not re-checked.
REQ-023 start deasserting outside IDLE has no effect.
REQ-024 Move-tick counter counts 0..MOVE_DIV-1 in WALK only, cleared on entry to WALK; a move occurs on the edge where counter = MOVE_DIV-1.
REQ-025 On a move with dir = 0: X <= min(X+STEP, X_MAX); with dir = 1: X <= max(X-STEP, X_MIN); sums computed 11 bits wide, no wrap.
REQ-026 turn <= 01 when in WALK, dir = 0 and next X = X_MAX; turn <= 10 when in WALK, dir = 1 and next X = X_MIN; else 00.
REQ-027 turn stays asserted each frame the condition holds (dir lags turn by one frame); X never moves past a bound while dir is stale.
REQ-028 kill and an edge condition in the same frame: kill wins, turn <= 00.
REQ-029 MonsterY constant except on spawn load.
REQ-030 anim_frame toggles every 8th frame in WALK; held in other states; cleared on entry to WALK.

Reset
REQ-031 Reset forces: state IDLE, X = SPAWN_X, Y = SPAWN_Y, turn = 00, alive = 0, squash = 0, anim_frame = 0, all counters 0.
REQ-032 Reset asserted mid-WALK/SQUASH/DEAD aborts immediately; no partial move or respawn completes.

Structure
REQ-033 Shared package monster_pkg holds the FSM state enum, turn codes TURN_NONE/TURN_RIGHT/TURN_LEFT, and the default bound/spawn constants.
REQ-034 One sub-module frame_tick_div (parameterised modulo counter with clear, tick output) provides the move tick; frame timers (death, respawn, animation) stay inline.

Verification
REQ-035 Reset, start=1, dir=0, STEP=2, MOVE_DIV=2 -> X 320,320,322,322,324... from first WALK edge; alive=1.
REQ-036 X=598, dir=0 -> next move X=600, turn=01 that frame; dir held 0 one more frame -> X stays 600, turn=01; dir=1 -> turn=00, X decrements to 598.
REQ-037 X=34, dir=1 -> X=32, turn=10; X never below 32.
REQ-038 kill=1 on same frame as right-edge hit -> turn=00, squash=1, X frozen; after 30 frames squash=0, state DEAD; after 120 more frames alive=1, X=320, Y=400.
REQ-039 Reset pulsed mid-SQUASH -> all outputs at reset values on the next observation; start=0 keeps IDLE indefinitely.
